// File: rtl/slot_alloc_if.sv
// Slot allocator request/response bundle.
// The master side issues alloc/free requests; the slave side (the allocator)
// returns the grant, the release error flag and the occupancy status.
interface slot_alloc_if #(
  parameter int NSLOT = 4,
  parameter int IDXW  = $clog2(NSLOT)
);
  logic              alloc_req;
  logic              free_vld;
  logic [IDXW-1:0]   free_idx;
  logic              alloc_gnt;
  logic [IDXW-1:0]   alloc_idx;
  logic [NSLOT-1:0]  busy_map;
  logic              full;
  logic              empty;
  logic [IDXW:0]     count;
  logic              err_free;

  modport master (
    output alloc_req, free_vld, free_idx,
    input  alloc_gnt, alloc_idx, busy_map, full, empty, count, err_free
  );

  modport slave (
    input  alloc_req, free_vld, free_idx,
    output alloc_gnt, alloc_idx, busy_map, full, empty, count, err_free
  );
endinterface

// File: rtl/slot_alloc.sv
// Slot allocator: grants the lowest free slot of an occupancy bitmap, one
// grant per cycle, and accepts releases of occupied slots. Releasing a free
// or out-of-range slot is rejected and flagged with a one-cycle error pulse.
// A slot released in a cycle only becomes a candidate from the next cycle,
// because the candidate is derived from the registered map.
module slot_alloc #(
  parameter int NSLOT = 4,
  parameter int IDXW  = $clog2(NSLOT)
) (
  input  logic         clk,
  input  logic         rst_n,
  slot_alloc_if.slave  bus
);

  localparam logic [IDXW:0] NSLOT_W = (IDXW+1)'(NSLOT);

  logic [NSLOT-1:0] busy_reg,  busy_next;
  logic [IDXW:0]    count_reg, count_next;
  logic [IDXW-1:0]  idx_reg,   idx_next;
  logic             gnt_reg,   gnt_next;
  logic             err_reg,   err_next;

  logic [NSLOT:0]   lower_busy;   // bit i: all slots below i are occupied
  logic [NSLOT-1:0] cand_onehot;  // lowest free slot, one-hot (zero when full)
  logic [NSLOT-1:0] free_mask;    // one-hot of an accepted release
  logic [IDXW-1:0]  cand_idx;
  logic             full_w;
  logic             alloc_ok;
  logic             idx_ok;
  logic             free_ok;

  assign full_w = &busy_reg;

  // Priority chain: a slot is the candidate when it is free and every lower
  // slot is busy.
  assign lower_busy[0] = 1'b1;
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_cand
    assign lower_busy[gi+1] = lower_busy[gi] & busy_reg[gi];
    assign cand_onehot[gi]  = lower_busy[gi] & ~busy_reg[gi];
  end

  // Encode the one-hot candidate into an index.
  always_comb begin
    cand_idx = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (cand_onehot[i]) cand_idx = cand_idx | IDXW'(i);
    end
  end

  assign alloc_ok = bus.alloc_req & ~full_w;
  assign idx_ok   = ({1'b0, bus.free_idx} < NSLOT_W);
  assign free_ok  = bus.free_vld & idx_ok & busy_reg[bus.free_idx];

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_free
    assign free_mask[gi] = free_ok && (bus.free_idx == IDXW'(gi));
  end

  // Next-state: the candidate is always a free bit and the released bit is
  // always a busy bit, so the set and clear masks never overlap.
  always_comb begin
    busy_next  = (busy_reg & ~free_mask) | (alloc_ok ? cand_onehot : '0);
    gnt_next   = alloc_ok;
    idx_next   = alloc_ok ? cand_idx : idx_reg;
    err_next   = bus.free_vld & ~free_ok;
    count_next = count_reg;
    case ({alloc_ok, free_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg  <= '0;
      count_reg <= '0;
      idx_reg   <= '0;
      gnt_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      busy_reg  <= busy_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
      gnt_reg   <= gnt_next;
      err_reg   <= err_next;
    end
  end

  assign bus.busy_map  = busy_reg;
  assign bus.count     = count_reg;
  assign bus.alloc_idx = idx_reg;
  assign bus.alloc_gnt = gnt_reg;
  assign bus.err_free  = err_reg;
  assign bus.full      = full_w;
  assign bus.empty     = ~|busy_reg;

endmodule

// File: tb/tb_slot_alloc.sv
// Self-checking bench for slot_alloc (NSLOT=4). Each driven cycle pushes the
// expected outcome into a scoreboard queue; it is popped and compared one
// edge later when the DUT registers its response.
module tb_slot_alloc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  slot_alloc_if #(.NSLOT(4)) bus ();

  slot_alloc #(.NSLOT(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       gnt;
    logic [1:0] idx;
    logic [3:0] busy;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_busy = 4'h0;
  logic [1:0] m_idx  = 2'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  64'(bus.busy_map),  64'h0);
    check({tag, "_count"}, 64'(bus.count),     64'h0);
    check({tag, "_gnt"},   64'(bus.alloc_gnt), 64'h0);
    check({tag, "_idx"},   64'(bus.alloc_idx), 64'h0);
    check({tag, "_err"},   64'(bus.err_free),  64'h0);
    check({tag, "_empty"}, 64'(bus.empty),     64'h1);
    check({tag, "_full"},  64'(bus.full),      64'h0);
  endtask

  // One cycle of stimulus; the model predicts the registered response.
  task automatic step(input logic req, input logic fv, input logic [1:0] fi);
    exp_t       e;
    exp_t       o;
    logic [3:0] nb;
    int         lz;
    @(negedge clk);
    bus.alloc_req = req;
    bus.free_vld  = fv;
    bus.free_idx  = fi;
    e.gnt = req && (m_busy != 4'hF);
    e.err = 1'b0;
    lz = 0;
    if (e.gnt) begin
      for (int i = 3; i >= 0; i--) if (!m_busy[i]) lz = i;
      m_idx = 2'(lz);
    end
    nb = m_busy;
    if (fv) begin
      if (m_busy[fi]) nb[fi] = 1'b0;
      else            e.err = 1'b1;
    end
    if (e.gnt) nb[lz] = 1'b1;
    m_busy = nb;
    e.idx  = m_idx;
    e.busy = nb;
    e.cnt  = 3'($countones(nb));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check("gnt",   64'(bus.alloc_gnt), 64'(o.gnt));
    check("idx",   64'(bus.alloc_idx), 64'(o.idx));
    check("busy",  64'(bus.busy_map),  64'(o.busy));
    check("count", 64'(bus.count),     64'(o.cnt));
    check("err",   64'(bus.err_free),  64'(o.err));
    check("full",  64'(bus.full),      64'(o.busy == 4'hF));
    check("empty", 64'(bus.empty),     64'(o.busy == 4'h0));
    $display("req=%0d fv=%0d fi=%0d -> gnt=%0d idx=%0d busy=%b cnt=%0d err=%0d",
             req, fv, fi, bus.alloc_gnt, bus.alloc_idx, bus.busy_map, bus.count, bus.err_free);
  endtask

  task automatic release_reset();
    @(negedge clk);
    bus.alloc_req = 1'b0;
    bus.free_vld  = 1'b0;
    bus.free_idx  = 2'd0;
    m_busy = 4'h0;
    m_idx  = 2'd0;
    rst_n  = 1'b1;
  endtask

  initial begin
    bus.alloc_req = 1'b0;
    bus.free_vld  = 1'b0;
    bus.free_idx  = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    release_reset();

    // Fill from empty: indices 0..3 on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 2'd0);
      check("fill_idx", 64'(bus.alloc_idx), 64'(i));
    end
    check("fill_busy",  64'(bus.busy_map), 64'hF);
    check("fill_count", 64'(bus.count),    64'd4);

    // Requests against a full map are dropped.
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    check("drop_gnt", 64'(bus.alloc_gnt), 64'h0);

    // Release slot 1, then reallocate it.
    step(1'b0, 1'b1, 2'd1);
    check("free1_busy", 64'(bus.busy_map), 64'hD);
    step(1'b1, 1'b0, 2'd0);
    check("realloc_idx", 64'(bus.alloc_idx), 64'd1);

    // From 0111: alloc with same-cycle release of slot 0 grants slot 3.
    step(1'b0, 1'b1, 2'd3);
    step(1'b1, 1'b1, 2'd0);
    check("simul_idx",  64'(bus.alloc_idx), 64'd3);
    check("simul_busy", 64'(bus.busy_map),  64'hE);

    // Full map with simultaneous alloc and release: release wins, alloc dropped.
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 2'd2);
    check("fullsim_busy", 64'(bus.busy_map), 64'hB);

    // Down to 0001, then an illegal release of slot 2.
    step(1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 2'd2);
    check("dbl_err",  64'(bus.err_free), 64'h1);
    check("dbl_busy", 64'(bus.busy_map), 64'h1);
    step(1'b0, 1'b0, 2'd0);
    check("err_pulse", 64'(bus.err_free), 64'h0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    // Reset mid-operation with a grant pending.
    rst_n = 1'b0;
    #2;
    release_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0);
    check("pre_rst_busy", 64'(bus.busy_map), 64'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bus.alloc_req = 1'b1;
    bus.free_vld  = 1'b1;
    bus.free_idx  = 2'd0;
    @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    release_reset();
    step(1'b1, 1'b0, 2'd0);
    check("post_rst_idx", 64'(bus.alloc_idx), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slot_alloc.md
SLOT_ALLOC -- requirements
Module: slot_alloc

Interface
REQ-001 SHALL have parameter NSLOT, default 4, number of allocatable slots (power of two, 2..64).
REQ-002 SHALL have parameter IDXW, default $clog2(NSLOT), slot index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port alloc_req  input  1  request one free slot this cycle.
REQ-006 SHALL have port free_vld  input  1  release the slot named by free_idx this cycle.
REQ-007 SHALL have port free_idx  input  IDXW  index of the slot to release.
REQ-008 SHALL have port alloc_gnt  output  1  registered one-cycle pulse; a slot was allocated in the previous cycle.
REQ-009 SHALL have port alloc_idx  output  IDXW  registered index of the granted slot; valid only while alloc_gnt is 1.
REQ-010 SHALL have port busy_map  output  NSLOT  registered occupancy bitmap; bit i = 1 means slot i is in use.
REQ-011 SHALL have port full  output  1  1 when all busy_map bits are 1.
REQ-012 SHALL have port empty  output  1  1 when all busy_map bits are 0.
REQ-013 SHALL have port count  output  IDXW+1  registered number of busy slots.
REQ-014 SHALL have port err_free  output  1  registered one-cycle pulse flagging an illegal release.

Function
REQ-015 SHALL select the candidate slot as the least-significant zero bit of busy_map, computed combinationally from the current registered busy_map.
REQ-016 SHALL accept an allocation when alloc_req=1 and full=0; at that edge the candidate bit SHALL be set, alloc_gnt SHALL be 1 next cycle, and alloc_idx SHALL hold the candidate index.
REQ-017 SHALL drop an allocation request when full=0 is false (full=1): no bit set, alloc_gnt=0 next cycle, alloc_idx holds its previous value. Requests are not queued.
REQ-018 SHALL give alloc-to-grant latency exactly 1 cycle and SHALL sustain one grant per cycle back-to-back.
REQ-019 SHALL accept a release when free_vld=1, free_idx<NSLOT and busy_map[free_idx]=1; the bit SHALL clear at that edge.
REQ-020 SHALL reject a release with free_idx>=NSLOT or busy_map[free_idx]=0 (double free): busy_map and count unchanged, err_free=1 for one cycle next cycle.
REQ-021 SHALL, on simultaneous alloc and release in one cycle, compute the candidate from the pre-release busy_map; a slot freed in cycle N SHALL NOT be granted before cycle N+1.
REQ-022 SHALL, on simultaneous alloc and release when full=1, accept the release and drop the allocation.
REQ-023 SHALL update count at each edge by +1 per accepted alloc and -1 per accepted release; both together leave it unchanged; count SHALL always equal popcount(busy_map).
REQ-024 SHALL derive full and empty combinationally from busy_map; full and empty are never both 1.
REQ-025 SHALL keep alloc_gnt and err_free as single-cycle pulses; neither SHALL remain high without a new qualifying event.

Reset
REQ-026 SHALL, while rst_n=0, immediately force busy_map=0, count=0, alloc_gnt=0, alloc_idx=0, err_free=0, so empty=1 and full=0.
REQ-027 SHALL, on reset mid-operation, discard all allocations and any pending grant/error pulse; the first edge after rst_n rises SHALL behave as from an empty map.
REQ-028 SHALL ignore alloc_req and free_vld while rst_n=0.

Verification (NSLOT=4)
REQ-029 SHALL cover: reset, alloc_req=1 for 4 cycles -> alloc_idx 0,1,2,3 on consecutive cycles, busy_map=4'b1111, full=1, count=4.
REQ-030 SHALL cover: full map, alloc_req=1 for 2 cycles -> alloc_gnt=0, busy_map unchanged, count=4.
REQ-031 SHALL cover: busy_map=4'b1111, free_idx=1 -> busy_map=4'b1101; then alloc -> alloc_idx=1, busy_map=4'b1111.
REQ-032 SHALL cover: busy_map=4'b0111, same-cycle alloc and free_idx=0 -> alloc_idx=3, busy_map=4'b1110, count=3.
REQ-033 SHALL cover: busy_map=4'b0001, free_idx=2 -> err_free pulse of 1 cycle, busy_map=4'b0001, count=1.
REQ-034 SHALL cover: busy_map=4'b0111 with grant pending, rst_n low mid-cycle -> outputs zero immediately; after release, alloc -> alloc_idx=0.
